// File: rtl/pcs_am_pkg.sv
// ---------------------------------------------------------------------------
// pcs_am_pkg
// Shared constants and the lock-FSM state encoding for the 100GbE PCS
// alignment-marker (AM) logic. The deskew and AM-removal blocks use it too.
//
// Contents:
//   N_LANES     - number of PCS lanes (legal lane IDs 0..N_LANES-1)
//   NB_LANE_ID  - width of a lane ID
//   AM_PERIOD   - valid blocks from one AM to the next on the same lane
//   MAX_INVALID - consecutive bad AM slots that cause loss of lock
//   am_state_e  - lock FSM states
// ---------------------------------------------------------------------------
package pcs_am_pkg;

    localparam int N_LANES     = 20;
    localparam int NB_LANE_ID  = 5;
    localparam int AM_PERIOD   = 16384;
    localparam int MAX_INVALID = 4;

    typedef enum logic [1:0] {
        FIND_1ST = 2'd0,   // hunting for a first AM
        COUNT_1  = 2'd1,   // one AM seen, waiting for a confirming AM
        LOCKED   = 2'd2    // AM lock held
    } am_state_e;

endpackage

// File: rtl/am_period_counter.sv
// ---------------------------------------------------------------------------
// am_period_counter
// Position counter for the AM period. It counts valid-block events and wraps
// so that an AM seen at event k puts the next expected AM at event
// k+N_BLOCKS. The deskew logic reuses it.
//
// Ports:
//   i_clock   - block clock
//   i_reset   - asynchronous, active-low reset
//   i_clear   - synchronous clear to pos=0 (has priority over i_event)
//   i_event   - one counted valid block this cycle
//   o_pos     - current position; the next event sees this value
//   o_at_slot - o_pos is N_BLOCKS-1, so the next event is the expected AM slot
// ---------------------------------------------------------------------------
module am_period_counter #(
    parameter int N_BLOCKS = 16384
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_clear,
    input  logic                        i_event,
    output logic [$clog2(N_BLOCKS)-1:0] o_pos,
    output logic                        o_at_slot
);

    localparam int              PW   = $clog2(N_BLOCKS);
    localparam logic [PW-1:0]   LAST = PW'(N_BLOCKS - 1);

    logic [PW-1:0] r_pos;

    // The slot event always reloads to 0, so a realigning AM at the slot
    // and a plain wrap produce the same count.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pos <= '0;
        end else if (i_clear) begin
            r_pos <= '0;
        end else if (i_event) begin
            if (r_pos == LAST) begin
                r_pos <= '0;
            end else begin
                r_pos <= r_pos + 1'b1;
            end
        end
    end

    assign o_pos     = r_pos;
    assign o_at_slot = (r_pos == LAST);

endmodule

// File: rtl/am_lock_fsm.sv
// ---------------------------------------------------------------------------
// am_lock_fsm
// Per-lane RX alignment-marker lock FSM. It takes the per-block hit from the
// lane's AM comparator. It acquires lock after two AMs with the same lane ID
// that are exactly N_BLOCKS valid blocks apart. It flags every expected AM
// slot and drops lock after MAX_INVALID consecutive bad slots.
//
// Qualification: a block counts only when i_enable=1 and i_valid=1 (an
// "event"). i_am_match/i_am_id are ignored on any other cycle. The
// interface has no backpressure.
//
// Ports:
//   i_clock         - block clock
//   i_reset         - asynchronous, active-low reset
//   i_enable        - lane enable; when 0, FSM and counter hold
//   i_valid         - a 66b block is presented this cycle
//   i_restart       - synchronous force to FIND_1ST (no lock-lost pulse)
//   i_am_match      - block matches some AM pattern
//   i_am_id         - lane ID of the matched AM
//   o_am_lock       - AM lock acquired (registered)
//   o_lane_id       - latched lane ID, valid while o_am_lock=1 (registered)
//   o_am_slot       - current event is the expected AM slot (combinational)
//   o_lock_lost     - one-cycle pulse when the bad-slot count drops lock
//   o_invalid_count - consecutive bad-slot count (registered)
//   o_dbg_state     - FSM state, for debug and checkers
//   o_dbg_pos       - period counter position, for debug and checkers
// ---------------------------------------------------------------------------
module am_lock_fsm #(
    parameter int N_BLOCKS    = pcs_am_pkg::AM_PERIOD,
    parameter int N_LANES     = pcs_am_pkg::N_LANES,
    parameter int MAX_INVALID = pcs_am_pkg::MAX_INVALID,
    parameter int NB_LANE_ID  = pcs_am_pkg::NB_LANE_ID
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_enable,
    input  logic                               i_valid,
    input  logic                               i_restart,
    input  logic                               i_am_match,
    input  logic [NB_LANE_ID-1:0]              i_am_id,
    output logic                               o_am_lock,
    output logic [NB_LANE_ID-1:0]              o_lane_id,
    output logic                               o_am_slot,
    output logic                               o_lock_lost,
    output logic [$clog2(MAX_INVALID+1)-1:0]   o_invalid_count,
    output logic [1:0]                         o_dbg_state,
    output logic [$clog2(N_BLOCKS)-1:0]        o_dbg_pos
);

    import pcs_am_pkg::*;

    localparam int PW = $clog2(N_BLOCKS);
    localparam int IW = $clog2(MAX_INVALID + 1);

    am_state_e              r_state,     w_state_nxt;
    logic [NB_LANE_ID-1:0]  r_lane_id,   w_lane_id_nxt;
    logic [IW-1:0]          r_invalid,   w_invalid_nxt;
    logic                   r_lock_lost, w_lock_lost_nxt;

    logic                   w_event;
    logic                   w_hit;
    logic                   w_same_id;
    logic                   w_at_slot;
    logic                   w_slot;
    logic                   w_clear;
    logic [PW-1:0]          w_pos;

    assign w_event   = i_enable & i_valid;
    // IDs at or above N_LANES are treated as no hit; zero-extend so the
    // compare works for any lane-ID width.
    assign w_hit     = i_am_match &
                       ({{(32-NB_LANE_ID){1'b0}}, i_am_id} < 32'(N_LANES));
    assign w_same_id = (i_am_id == r_lane_id);
    assign w_slot    = w_event & w_at_slot & (r_state != FIND_1ST);

    // Only the first AM found in FIND_1ST needs an explicit realign. At a
    // slot the counter wraps to 0 anyway.
    assign w_clear   = i_restart | (w_event & w_hit & (r_state == FIND_1ST));

    am_period_counter #(
        .N_BLOCKS (N_BLOCKS)
    ) u_period (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_clear),
        .i_event   (w_event),
        .o_pos     (w_pos),
        .o_at_slot (w_at_slot)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= FIND_1ST;
            r_lane_id   <= '0;
            r_invalid   <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane_id   <= w_lane_id_nxt;
            r_invalid   <= w_invalid_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lane_id_nxt   = r_lane_id;
        w_invalid_nxt   = r_invalid;
        w_lock_lost_nxt = 1'b0;

        if (i_restart) begin
            // The lane ID is kept on restart. It only matters once locked again.
            w_state_nxt   = FIND_1ST;
            w_invalid_nxt = '0;
        end else if (w_event) begin
            case (r_state)
                FIND_1ST: begin
                    if (w_hit) begin
                        w_lane_id_nxt = i_am_id;
                        w_state_nxt   = COUNT_1;
                    end
                end
                COUNT_1: begin
                    // Hits away from the slot are ignored.
                    if (w_at_slot) begin
                        if (w_hit && w_same_id) begin
                            w_state_nxt   = LOCKED;
                            w_invalid_nxt = '0;
                        end else if (w_hit) begin
                            // A new ID at the right spacing becomes the
                            // next candidate. The counter has already wrapped.
                            w_lane_id_nxt = i_am_id;
                        end else begin
                            w_state_nxt = FIND_1ST;
                        end
                    end
                end
                LOCKED: begin
                    // Off-slot hits never realign a held lock.
                    if (w_at_slot) begin
                        if (w_hit && w_same_id) begin
                            w_invalid_nxt = '0;
                        end else if (r_invalid == IW'(MAX_INVALID - 1)) begin
                            w_state_nxt     = FIND_1ST;
                            w_invalid_nxt   = '0;
                            w_lock_lost_nxt = 1'b1;
                        end else begin
                            w_invalid_nxt = r_invalid + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = FIND_1ST;
                end
            endcase
        end
    end

    assign o_am_lock       = (r_state == LOCKED);
    assign o_lane_id       = r_lane_id;
    assign o_am_slot       = w_slot;
    assign o_lock_lost     = r_lock_lost;
    assign o_invalid_count = r_invalid;
    assign o_dbg_state     = r_state;
    assign o_dbg_pos       = w_pos;

endmodule

// File: tb/tb_am_lock_fsm.sv
// ---------------------------------------------------------------------------
// tb_am_lock_fsm
// Directed bench for am_lock_fsm with N_BLOCKS=8. A block-level model tracks
// lock status, candidate ID, bad-slot count and the event index of the last
// AM. An event is the expected slot when it lies a whole number of periods
// after that AM. Literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_am_lock_fsm;
    import pcs_am_pkg::*;

    localparam int NB = 8;
    localparam int NL = 20;
    localparam int MI = 4;

    // ---------------- clock / reset ----------------
    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       valid   = 1'b0;
    logic       restart = 1'b0;
    logic       match   = 1'b0;
    logic [4:0] id      = '0;

    logic       o_am_lock;
    logic [4:0] o_lane_id;
    logic       o_am_slot;
    logic       o_lock_lost;
    logic [2:0] o_invalid_count;
    logic [1:0] o_dbg_state;
    logic [2:0] o_dbg_pos;

    always #5 clk = ~clk;

    am_lock_fsm #(
        .N_BLOCKS    (NB),
        .N_LANES     (NL),
        .MAX_INVALID (MI),
        .NB_LANE_ID  (5)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_enable        (en),
        .i_valid         (valid),
        .i_restart       (restart),
        .i_am_match      (match),
        .i_am_id         (id),
        .o_am_lock       (o_am_lock),
        .o_lane_id       (o_lane_id),
        .o_am_slot       (o_am_slot),
        .o_lock_lost     (o_lock_lost),
        .o_invalid_count (o_invalid_count),
        .o_dbg_state     (o_dbg_state),
        .o_dbg_pos       (o_dbg_pos)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 = searching, 1 = one AM seen, 2 = locked.
    // m_anchor: event index of the last AM (or the equivalent after restart).
    int m_phase  = 0;
    int m_ev     = 0;
    int m_anchor = -1;
    int m_id     = 0;
    int m_bad    = 0;
    int m_lost   = 0;
    bit m_hit;
    bit m_slot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_ev = 0; m_anchor = -1; m_id = 0; m_bad = 0; m_lost = 0;
        end else begin
            m_lost = 0;
            if (restart) begin
                m_phase  = 0;
                m_bad    = 0;
                m_anchor = m_ev - 1;
            end else if (en && valid) begin
                m_hit  = match && (int'(id) < NL);
                m_slot = (m_phase != 0) && ((m_ev - m_anchor) % NB == 0);
                if (m_phase == 0) begin
                    if (m_hit) begin
                        m_id = int'(id); m_phase = 1; m_anchor = m_ev;
                    end
                end else if (m_slot) begin
                    m_anchor = m_ev;
                    if (m_phase == 1) begin
                        if (m_hit && int'(id) == m_id) begin
                            m_phase = 2; m_bad = 0;
                        end else if (m_hit) begin
                            m_id = int'(id);
                        end else begin
                            m_phase = 0;
                        end
                    end else begin
                        if (m_hit && int'(id) == m_id) begin
                            m_bad = 0;
                        end else begin
                            m_bad++;
                            if (m_bad == MI) begin
                                m_phase = 0; m_bad = 0; m_lost = 1;
                            end
                        end
                    end
                end
                m_ev++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int exp_slot;
        exp_slot = (rst_n && en && valid && m_phase != 0 &&
                    ((m_ev - m_anchor) % NB == 0)) ? 1 : 0;
        chk("am_slot",       int'(o_am_slot),       exp_slot);
        chk("am_lock",       int'(o_am_lock),       (m_phase == 2) ? 1 : 0);
        chk("lane_id",       int'(o_lane_id),       m_id);
        chk("invalid_count", int'(o_invalid_count), m_bad);
        chk("lock_lost",     int'(o_lock_lost),     m_lost);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic e, input logic v, input logic r,
                        input logic m, input logic [4:0] i);
        @(posedge clk);
        #1;
        en = e; valid = v; restart = r; match = m; id = i;
        @(negedge clk);
    endtask

    task automatic ev(input logic m, input logic [4:0] i);
        step(1'b1, 1'b1, 1'b0, m, i);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) ev(1'b0, 5'd0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic lock_on(input logic [4:0] i);
        ev(1'b1, i);
        gap(NB - 1);
        ev(1'b1, i);
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lock",  int'(o_am_lock),       0);
        chk("rst_id",    int'(o_lane_id),       0);
        chk("rst_slot",  int'(o_am_slot),       0);
        chk("rst_lost",  int'(o_lock_lost),     0);
        chk("rst_inv",   int'(o_invalid_count), 0);
        chk("rst_state", int'(o_dbg_state),     int'(FIND_1ST));
        rst_n = 1'b1;

        // Out-of-range ID does not start a search.
        ev(1'b1, 5'd25);
        idle();
        chk("bad_id_state", int'(o_dbg_state), int'(FIND_1ST));

        // Basic acquisition: AM at event 0, slot at event 8.
        ev(1'b1, 5'd3);
        gap(NB - 1);
        ev(1'b1, 5'd3);
        chk("t1_slot", int'(o_am_slot), 1);
        chk("t1_pos",  int'(o_dbg_pos), 7);
        idle();
        chk("t1_lock", int'(o_am_lock), 1);
        chk("t1_id",   int'(o_lane_id), 3);

        // Four missing AMs -> loss of lock.
        for (int k = 1; k <= MI; k++) begin
            gap(NB - 1);
            ev(1'b0, 5'd0);
            chk("t2_slot", int'(o_am_slot), 1);
            idle();
            if (k < MI) begin
                chk("t2_inv",  int'(o_invalid_count), k);
                chk("t2_lock", int'(o_am_lock), 1);
            end else begin
                chk("t2_lost",  int'(o_lock_lost), 1);
                chk("t2_unlk",  int'(o_am_lock), 0);
                chk("t2_inv0",  int'(o_invalid_count), 0);
                chk("t2_state", int'(o_dbg_state), int'(FIND_1ST));
            end
        end
        idle();
        chk("t2_pulse_end", int'(o_lock_lost), 0);

        // Three bad slots, an ignored off-slot hit, then a good slot.
        lock_on(5'd3);
        chk("t3_lock", int'(o_am_lock), 1);
        for (int k = 0; k < 3; k++) begin
            gap(NB - 1);
            ev(1'b0, 5'd0);
        end
        idle();
        chk("t3_inv3", int'(o_invalid_count), 3);
        gap(4);
        ev(1'b1, 5'd3);
        chk("t3_off_pos",  int'(o_dbg_pos), 4);
        chk("t3_off_slot", int'(o_am_slot), 0);
        gap(2);
        ev(1'b1, 5'd3);
        chk("t3_slot",     int'(o_am_slot), 1);
        chk("t3_slot_pos", int'(o_dbg_pos), 7);
        idle();
        chk("t3_inv0",  int'(o_invalid_count), 0);
        chk("t3_held",  int'(o_am_lock), 1);

        // Candidate ID replaced at the slot, then confirmed.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        idle();
        chk("t4_unlk", int'(o_am_lock), 0);
        chk("t4_nopulse", int'(o_lock_lost), 0);
        ev(1'b1, 5'd3);
        gap(NB - 1);
        ev(1'b1, 5'd5);
        idle();
        chk("t4_nolock", int'(o_am_lock), 0);
        chk("t4_relatch", int'(o_lane_id), 5);
        gap(NB - 1);
        ev(1'b1, 5'd5);
        idle();
        chk("t4_lock", int'(o_am_lock), 1);
        chk("t4_id",   int'(o_lane_id), 5);

        // Non-event cycles (with matches present) are not counted.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        ev(1'b1, 5'd3);
        for (int k = 0; k < NB - 1; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
            ev(1'b0, 5'd0);
            step(1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
        end
        ev(1'b1, 5'd3);
        chk("t5_slot", int'(o_am_slot), 1);
        idle();
        chk("t5_lock", int'(o_am_lock), 1);
        chk("t5_id",   int'(o_lane_id), 3);

        // Restart on a slot wins and gives no pulse.
        gap(NB - 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
        chk("t6_slot", int'(o_am_slot), 1);
        idle();
        chk("t6_unlk", int'(o_am_lock), 0);
        chk("t6_nopulse", int'(o_lock_lost), 0);

        // Asynchronous reset mid-count clears everything at once.
        lock_on(5'd3);
        chk("t6_relock", int'(o_am_lock), 1);
        gap(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ar_lock", int'(o_am_lock),       0);
        chk("t6_ar_id",   int'(o_lane_id),       0);
        chk("t6_ar_slot", int'(o_am_slot),       0);
        chk("t6_ar_inv",  int'(o_invalid_count), 0);
        chk("t6_ar_pos",  int'(o_dbg_pos),       0);
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0; valid = 1'b0; match = 1'b0;
        rst_n = 1'b1;
        lock_on(5'd7);
        chk("t6_post_lock", int'(o_am_lock), 1);
        chk("t6_post_id",   int'(o_lane_id), 7);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_lock_fsm.md
Name: am_lock_fsm

Overview:
- Per-lane RX alignment-marker lock FSM for the 100GbE PCS. It pairs with the TX-side AM insertion timer.
- Consumes the per-block hit from the lane's AM comparator.
- Acquires lock after two AMs with the same lane ID spaced exactly N_BLOCKS valid blocks apart.
- Flags every expected AM slot for deskew/AM removal, and drops lock after MAX_INVALID consecutive bad AM slots.

Parameters:
N_BLOCKS, 16384, valid blocks from one AM to the next AM on the same lane (AM included in the count)
N_LANES, 20, number of PCS lanes (legal lane IDs 0..N_LANES-1)
MAX_INVALID, 4, consecutive bad AM slots that cause loss of lock
NB_LANE_ID, 5, width of lane ID

Ports:
i_clock  in  1  block clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  lane enable; when 0, FSM and counter hold state
i_valid  in  1  a 66b block is presented this cycle
i_restart  in  1  block-lock lost or lane re-init; sync force to INIT
i_am_match  in  1  current block matches some AM pattern (qualified by i_valid)
i_am_id  in  NB_LANE_ID  lane ID of the matched AM (meaningful when i_am_match=1)
o_am_lock  out  1  AM lock acquired
o_lane_id  out  NB_LANE_ID  locked physical-to-logical lane ID
o_am_slot  out  1  current valid block sits in the expected AM position (combinational)
o_lock_lost  out  1  one-cycle pulse when lock is dropped by the invalid count
o_invalid_count  out  clog2(MAX_INVALID+1)  current consecutive bad-slot count

Behaviour:
- Reset (i_reset=0, async):
  - state=FIND_1ST, pos=0, invalid=0, lane_id=0.
  - All outputs 0.
- Event: an event is a cycle with i_enable=1 and i_valid=1. Non-event cycles change nothing.
- i_restart=1 (synchronous, overrides everything):
  - state=FIND_1ST, pos=0, invalid=0, o_am_lock=0.
  - No o_lock_lost pulse.
- Hit: i_am_match=1 and i_am_id<N_LANES. An ID >= N_LANES is treated as no hit.
- Position counter pos, width clog2(N_BLOCKS):
  - An accepted AM sets pos=0.
  - Every later event with pos<N_BLOCKS-1 increments pos.
  - The event seen with pos==N_BLOCKS-1 is the expected AM slot; it always reloads pos=0 (wrap).
  - Net effect: an AM at event k implies the next AM at event k+N_BLOCKS.
- Slot flag: o_am_slot = event & (state in {COUNT_1, LOCKED}) & pos==N_BLOCKS-1.
- States:
  - FIND_1ST: on event with hit, latch lane_id=i_am_id, pos=0, go to COUNT_1. Otherwise stay.
  - COUNT_1: count events. A hit before the slot is ignored. At the slot:
    - hit with same id: o_am_lock=1 from next cycle, invalid=0, go to LOCKED.
    - hit with different id: latch new id, pos=0, stay in COUNT_1.
    - no hit: go to FIND_1ST.
  - LOCKED: count events. At the slot:
    - hit with id==lane_id: invalid=0.
    - otherwise: invalid+1.
    - If invalid+1 reaches MAX_INVALID: go to FIND_1ST, o_am_lock=0, invalid=0, o_lock_lost=1 for one cycle.
    - A hit outside the slot is ignored; lock holds and the counter does not realign.
- Latency:
  - o_am_lock, o_lane_id and o_invalid_count are registered and update the cycle after the deciding slot.
  - o_am_slot has zero latency.
- o_lane_id holds its last latched value while unlocked; it is valid only when o_am_lock=1.
- Simultaneous i_restart with a slot event: restart wins and no pulse is produced.

Decomposition:
- Shared package pcs_am_pkg:
  - Constants N_LANES, NB_LANE_ID, AM_PERIOD=16384, MAX_INVALID=4.
  - State encoding FIND_1ST, COUNT_1, LOCKED.
- One sub-module, am_period_counter:
  - Inputs: clear, event.
  - Outputs: pos, at_slot.
  - Wrap at N_BLOCKS-1; reusable by the deskew logic.

Test Plan:
- N_BLOCKS=8. Hit id=3 at event 0, no hits at events 1..7, hit id=3 at event 8 -> o_am_slot=1 at event 8; o_am_lock=1 and o_lane_id=3 one cycle later.
- Locked on id=3. Slots 1..3 have no hit -> o_invalid_count 1,2,3 with lock held. Slot 4 has no hit -> o_lock_lost pulse, o_am_lock=0, state FIND_1ST.
- Locked. 3 bad slots then a good slot (id=3) -> o_invalid_count returns to 0 and lock is held. A hit id=3 at pos=4 -> ignored, slot stays at pos 7.
- COUNT_1 with id=3. Slot carries id=5 -> no lock, id re-latched to 5. Next slot with id=5 -> lock with o_lane_id=5.
- Interleave i_valid=0 and i_enable=0 cycles between events -> slot timing counts events only; lock is still acquired at event 8.
- Locked. Assert i_restart on a slot cycle -> o_am_lock=0, no o_lock_lost. Async i_reset=0 mid-count -> all outputs 0 immediately.
